// File: rtl/refill_req_arbiter.sv
// Two-requester round-robin arbiter in front of the L1.5 request channel.
// The winning request is held in a one-entry output slot until the memory
// side accepts it. A per-requester count of in-flight transactions is kept,
// and each response is routed back to its originator by source ID.
module refill_req_arbiter #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned WDataWidth     = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // icache refill requests
  input  logic                  icache_req_valid_i,
  output logic                  icache_req_ready_o,
  input  logic [AddrWidth-1:0]  icache_req_addr_i,
  // dcache miss / write-through requests
  input  logic                  dcache_req_valid_i,
  output logic                  dcache_req_ready_o,
  input  logic [AddrWidth-1:0]  dcache_req_addr_i,
  input  logic                  dcache_req_we_i,
  input  logic [WDataWidth-1:0] dcache_req_wdata_i,
  // memory request channel
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [AddrWidth-1:0]  mem_req_addr_o,
  output logic                  mem_req_we_o,
  output logic [WDataWidth-1:0] mem_req_wdata_o,
  output logic                  mem_req_id_o,
  // memory responses
  input  logic                  mem_rsp_valid_i,
  input  logic                  mem_rsp_id_i,
  input  logic [LineWidth-1:0]  mem_rsp_data_i,
  // routed responses
  output logic                  icache_rsp_valid_o,
  output logic [LineWidth-1:0]  icache_rsp_data_o,
  output logic                  dcache_rsp_valid_o,
  output logic [LineWidth-1:0]  dcache_rsp_data_o,
  output logic                  err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { SRC_ICACHE = 1'b0, SRC_DCACHE = 1'b1 } src_t;

  state_t                state;
  src_t                  last_grant;
  logic                  slot_valid;
  logic [AddrWidth-1:0]  slot_addr;
  logic                  slot_we;
  logic [WDataWidth-1:0] slot_wdata;
  logic                  slot_id;

  logic [CntWidth-1:0]   cnt_icache;
  logic [CntWidth-1:0]   cnt_dcache;
  logic [CntWidth-1:0]   cnt_icache_next;
  logic [CntWidth-1:0]   cnt_dcache_next;
  logic                  err;

  logic elig_icache;
  logic elig_dcache;
  logic win_icache;
  logic win_dcache;
  logic slot_free;
  logic acc_icache;
  logic acc_dcache;
  logic rsp_icache;
  logic rsp_dcache;
  logic dec_icache;
  logic dec_dcache;
  logic rsp_orphan;

  // Eligibility, round-robin grant and ready generation
  always_comb begin
    elig_icache = icache_req_valid_i && (cnt_icache < CntMax);
    elig_dcache = dcache_req_valid_i && (cnt_dcache < CntMax);
    // On a tie the requester that did not win last time goes first.
    win_icache  = elig_icache && (!elig_dcache || (last_grant == SRC_DCACHE));
    win_dcache  = elig_dcache && (!elig_icache || (last_grant == SRC_ICACHE));
    // A full slot that drains this cycle can be refilled in the same cycle.
    slot_free   = (state == IDLE) || mem_req_ready_i;
    icache_req_ready_o = slot_free && win_icache;
    dcache_req_ready_o = slot_free && win_dcache;
    acc_icache  = icache_req_valid_i && icache_req_ready_o;
    acc_dcache  = dcache_req_valid_i && dcache_req_ready_o;
  end

  // Response decode and outstanding-count bookkeeping
  always_comb begin
    rsp_icache = mem_rsp_valid_i && (mem_rsp_id_i == 1'b0);
    rsp_dcache = mem_rsp_valid_i && (mem_rsp_id_i == 1'b1);
    // Responses for a requester with nothing in flight never underflow.
    dec_icache = rsp_icache && (cnt_icache != '0);
    dec_dcache = rsp_dcache && (cnt_dcache != '0);
    rsp_orphan = (rsp_icache && (cnt_icache == '0)) ||
                 (rsp_dcache && (cnt_dcache == '0));

    cnt_icache_next = cnt_icache;
    unique case ({acc_icache, dec_icache})
      2'b10:   cnt_icache_next = cnt_icache + CntOne;
      2'b01:   cnt_icache_next = cnt_icache - CntOne;
      default: cnt_icache_next = cnt_icache;
    endcase

    cnt_dcache_next = cnt_dcache;
    unique case ({acc_dcache, dec_dcache})
      2'b10:   cnt_dcache_next = cnt_dcache + CntOne;
      2'b01:   cnt_dcache_next = cnt_dcache - CntOne;
      default: cnt_dcache_next = cnt_dcache;
    endcase
  end

  // Slot FSM: load on accept, hold while stalled, empty on drain
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= SRC_DCACHE;
      slot_valid <= 1'b0;
      slot_addr  <= '0;
      slot_we    <= 1'b0;
      slot_wdata <= '0;
      slot_id    <= 1'b0;
    end else if (acc_icache) begin
      state      <= BUSY;
      last_grant <= SRC_ICACHE;
      slot_valid <= 1'b1;
      slot_addr  <= icache_req_addr_i;
      slot_we    <= 1'b0;
      slot_wdata <= '0;
      slot_id    <= 1'b0;
    end else if (acc_dcache) begin
      state      <= BUSY;
      last_grant <= SRC_DCACHE;
      slot_valid <= 1'b1;
      slot_addr  <= dcache_req_addr_i;
      slot_we    <= dcache_req_we_i;
      slot_wdata <= dcache_req_wdata_i;
      slot_id    <= 1'b1;
    end else if ((state == BUSY) && mem_req_ready_i) begin
      state      <= IDLE;
      slot_valid <= 1'b0;
    end
  end

  // Outstanding counters and sticky orphan-response flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_icache <= '0;
      cnt_dcache <= '0;
      err        <= 1'b0;
    end else begin
      cnt_icache <= cnt_icache_next;
      cnt_dcache <= cnt_dcache_next;
      if (rsp_orphan) begin
        err <= 1'b1;
      end
    end
  end

  // Registered request outputs
  always_comb begin
    mem_req_valid_o = slot_valid;
    mem_req_addr_o  = slot_addr;
    mem_req_we_o    = slot_we;
    mem_req_wdata_o = slot_wdata;
    mem_req_id_o    = slot_id;
    err_o           = err;
  end

  // Combinational response routing
  always_comb begin
    icache_rsp_valid_o = rsp_icache;
    dcache_rsp_valid_o = rsp_dcache;
    icache_rsp_data_o  = mem_rsp_data_i;
    dcache_rsp_data_o  = mem_rsp_data_i;
  end

endmodule

// File: tb/tb_refill_req_arbiter.sv
// Self-checking bench for refill_req_arbiter: a cycle table for contention,
// outstanding limit and simultaneous accept/response, hand-written sequences
// for orphan response, mid-operation reset and back-pressure, and a request
// scoreboard that checks every memory handshake against what was accepted.
module tb_refill_req_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         icache_req_valid;
  logic         icache_req_ready;
  logic [63:0]  icache_req_addr;
  logic         dcache_req_valid;
  logic         dcache_req_ready;
  logic [63:0]  dcache_req_addr;
  logic         dcache_req_we;
  logic [63:0]  dcache_req_wdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_addr;
  logic         mem_req_we;
  logic [63:0]  mem_req_wdata;
  logic         mem_req_id;
  logic         mem_rsp_valid;
  logic         mem_rsp_id;
  logic [127:0] mem_rsp_data;
  logic         icache_rsp_valid;
  logic [127:0] icache_rsp_data;
  logic         dcache_rsp_valid;
  logic [127:0] dcache_rsp_data;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  refill_req_arbiter #(
    .AddrWidth(64),
    .LineWidth(128),
    .WDataWidth(64),
    .MaxOutstanding(4)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .icache_req_valid_i (icache_req_valid),
    .icache_req_ready_o (icache_req_ready),
    .icache_req_addr_i  (icache_req_addr),
    .dcache_req_valid_i (dcache_req_valid),
    .dcache_req_ready_o (dcache_req_ready),
    .dcache_req_addr_i  (dcache_req_addr),
    .dcache_req_we_i    (dcache_req_we),
    .dcache_req_wdata_i (dcache_req_wdata),
    .mem_req_valid_o    (mem_req_valid),
    .mem_req_ready_i    (mem_req_ready),
    .mem_req_addr_o     (mem_req_addr),
    .mem_req_we_o       (mem_req_we),
    .mem_req_wdata_o    (mem_req_wdata),
    .mem_req_id_o       (mem_req_id),
    .mem_rsp_valid_i    (mem_rsp_valid),
    .mem_rsp_id_i       (mem_rsp_id),
    .mem_rsp_data_i     (mem_rsp_data),
    .icache_rsp_valid_o (icache_rsp_valid),
    .icache_rsp_data_o  (icache_rsp_data),
    .dcache_rsp_valid_o (dcache_rsp_valid),
    .dcache_rsp_data_o  (dcache_rsp_data),
    .err_o              (err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic        id;
  } req_t;

  req_t sb_q[$];

  always @(negedge clk) begin
    req_t e;
    if (!rst_ni) begin
      sb_q.delete();
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          check("sb_addr",  128'(mem_req_addr),  128'(e.addr));
          check("sb_we",    128'(mem_req_we),    128'(e.we));
          check("sb_wdata", 128'(mem_req_wdata), 128'(e.wdata));
          check("sb_id",    128'(mem_req_id),    128'(e.id));
        end
      end
      if (icache_req_valid && icache_req_ready) begin
        e.addr = icache_req_addr; e.we = 1'b0; e.wdata = '0; e.id = 1'b0;
        sb_q.push_back(e);
      end
      if (dcache_req_valid && dcache_req_ready) begin
        e.addr = dcache_req_addr; e.we = dcache_req_we; e.wdata = dcache_req_wdata; e.id = 1'b1;
        sb_q.push_back(e);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int iv, dv, mr, rv, rid;          // inputs
    int ir, dr, mv, mid, irv, drv;    // expected outputs this cycle
    int ci, cd;                       // expected counts this cycle
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  task automatic idle_inputs();
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_id       = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int ci, input int cd);
    check({tag, "_cnt_i"}, 128'(dut.cnt_icache), 128'(ci));
    check({tag, "_cnt_d"}, 128'(dut.cnt_dcache), 128'(cd));
  endtask

  initial begin
    //            iv dv mr rv rid  ir dr mv mid irv drv  ci cd
    vecs[0]  = '{ 1, 1, 1, 0, 0,   1, 0, 0, 0,  0,  0,   0, 0 };
    vecs[1]  = '{ 1, 1, 1, 0, 0,   0, 1, 1, 0,  0,  0,   1, 0 };
    vecs[2]  = '{ 1, 1, 1, 0, 0,   1, 0, 1, 1,  0,  0,   1, 1 };
    vecs[3]  = '{ 1, 1, 1, 0, 0,   0, 1, 1, 0,  0,  0,   2, 1 };
    vecs[4]  = '{ 1, 1, 1, 0, 0,   1, 0, 1, 1,  0,  0,   2, 2 };
    vecs[5]  = '{ 1, 1, 1, 0, 0,   0, 1, 1, 0,  0,  0,   3, 2 };
    vecs[6]  = '{ 1, 1, 1, 0, 0,   1, 0, 1, 1,  0,  0,   3, 3 };
    vecs[7]  = '{ 1, 1, 1, 0, 0,   0, 1, 1, 0,  0,  0,   4, 3 };
    vecs[8]  = '{ 1, 1, 1, 0, 0,   0, 0, 1, 1,  0,  0,   4, 4 };
    vecs[9]  = '{ 1, 1, 1, 1, 0,   0, 0, 0, 0,  1,  0,   4, 4 };
    vecs[10] = '{ 1, 1, 1, 0, 0,   1, 0, 0, 0,  0,  0,   3, 4 };
    vecs[11] = '{ 1, 1, 1, 0, 0,   0, 0, 1, 0,  0,  0,   4, 4 };
    vecs[12] = '{ 0, 0, 1, 1, 0,   0, 0, 0, 0,  1,  0,   4, 4 };
    vecs[13] = '{ 0, 0, 1, 1, 0,   0, 0, 0, 0,  1,  0,   3, 4 };
    vecs[14] = '{ 1, 0, 1, 1, 0,   1, 0, 0, 0,  1,  0,   2, 4 };
    vecs[15] = '{ 0, 0, 1, 0, 0,   0, 0, 1, 0,  0,  0,   2, 4 };
    vecs[16] = '{ 0, 0, 1, 0, 0,   0, 0, 0, 0,  0,  0,   2, 4 };

    rst_ni = 1'b0;
    idle_inputs();
    icache_req_addr  = '0;
    dcache_req_addr  = '0;
    dcache_req_we    = 1'b0;
    dcache_req_wdata = '0;
    mem_rsp_data     = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 128'(mem_req_valid), 128'(0));
    check("rst_mem_addr",  128'(mem_req_addr),  128'(0));
    check("rst_mem_we",    128'(mem_req_we),    128'(0));
    check("rst_mem_wdata", 128'(mem_req_wdata), 128'(0));
    check("rst_mem_id",    128'(mem_req_id),    128'(0));
    check("rst_err",       128'(err),           128'(0));

    // Table: contention, outstanding limit, simultaneous accept + response
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      rst_ni           = 1'b1;
      icache_req_valid = (vecs[i].iv != 0);
      dcache_req_valid = (vecs[i].dv != 0);
      mem_req_ready    = (vecs[i].mr != 0);
      mem_rsp_valid    = (vecs[i].rv != 0);
      mem_rsp_id       = (vecs[i].rid != 0);
      icache_req_addr  = 64'h1000 + 64'(i) * 64'h40;
      dcache_req_addr  = 64'h2000 + 64'(i) * 64'h40;
      dcache_req_we    = (i % 2) == 1;
      dcache_req_wdata = 64'hA000_0000_0000_0000 | 64'(i);
      mem_rsp_data     = {64'h5555_0000_0000_0000, 64'(i)};
      @(negedge clk);
      check($sformatf("v%0d_iready", i), 128'(icache_req_ready), 128'(vecs[i].ir));
      check($sformatf("v%0d_dready", i), 128'(dcache_req_ready), 128'(vecs[i].dr));
      check($sformatf("v%0d_mvalid", i), 128'(mem_req_valid),    128'(vecs[i].mv));
      if (vecs[i].mv != 0)
        check($sformatf("v%0d_mid", i), 128'(mem_req_id), 128'(vecs[i].mid));
      check($sformatf("v%0d_irsp", i), 128'(icache_rsp_valid), 128'(vecs[i].irv));
      check($sformatf("v%0d_drsp", i), 128'(dcache_rsp_valid), 128'(vecs[i].drv));
      if (vecs[i].rv != 0)
        check($sformatf("v%0d_idata", i), icache_rsp_data, mem_rsp_data);
      check_counts($sformatf("v%0d", i), vecs[i].ci, vecs[i].cd);
    end
    check("tbl_err", 128'(err), 128'(0));

    // Orphan response to dcache right after reset
    @(posedge clk); #1;
    idle_inputs();
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni        = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 1'b1;
    mem_rsp_data  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5;
    @(negedge clk);
    check("orph_drsp",  128'(dcache_rsp_valid), 128'(1));
    check("orph_irsp",  128'(icache_rsp_valid), 128'(0));
    check("orph_ddata", dcache_rsp_data, 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A5);
    check("orph_err0",  128'(err), 128'(0));
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("orph_err1", 128'(err), 128'(1));
    check_counts("orph", 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("orph_sticky", 128'(err), 128'(1));

    // Build cnt = {3,2} under contention, then reset while BUSY
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      icache_req_valid = 1'b1;
      dcache_req_valid = 1'b1;
      mem_req_ready    = 1'b1;
      icache_req_addr  = 64'h3000 + 64'(k) * 64'h40;
      dcache_req_addr  = 64'h4000 + 64'(k) * 64'h40;
      dcache_req_we    = 1'b0;
      @(negedge clk);
      check($sformatf("mr%0d_iready", k), 128'(icache_req_ready), 128'((k % 2) == 0));
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    check("mr_busy", 128'(mem_req_valid), 128'(1));
    check("mr_id",   128'(mem_req_id),    128'(0));
    check_counts("mr_pre", 3, 2);
    @(posedge clk); #1;
    rst_ni           = 1'b1;
    icache_req_valid = 1'b1;
    dcache_req_valid = 1'b1;
    mem_req_ready    = 1'b1;
    icache_req_addr  = 64'h5000;
    @(negedge clk);
    check("mr_post_valid", 128'(mem_req_valid), 128'(0));
    check("mr_post_err",   128'(err),           128'(0));
    check_counts("mr_post", 0, 0);
    check("mr_tie_iready", 128'(icache_req_ready), 128'(1));
    check("mr_tie_dready", 128'(dcache_req_ready), 128'(0));
    @(posedge clk); #1;
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    mem_rsp_valid    = 1'b1;
    mem_rsp_id       = 1'b1;
    @(negedge clk);
    check("mr_new_valid", 128'(mem_req_valid), 128'(1));
    check("mr_new_id",    128'(mem_req_id),    128'(0));
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("mr_stale_err", 128'(err), 128'(1));

    // Back-pressure: dcache write accepted, memory stalls for 5 cycles
    @(posedge clk); #1;
    dcache_req_valid = 1'b1;
    dcache_req_addr  = 64'h8000_1000;
    dcache_req_we    = 1'b1;
    dcache_req_wdata = 64'hDEAD_BEEF;
    mem_req_ready    = 1'b0;
    @(negedge clk);
    check("bp_accept", 128'(dcache_req_ready), 128'(1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      icache_req_valid = 1'b1;
      dcache_req_valid = 1'b1;
      dcache_req_addr  = 64'h9000 + 64'(k);
      dcache_req_wdata = 64'h1111 * 64'(k + 1);
      @(negedge clk);
      check($sformatf("bp%0d_valid", k),  128'(mem_req_valid),    128'(1));
      check($sformatf("bp%0d_addr", k),   128'(mem_req_addr),     128'(64'h8000_1000));
      check($sformatf("bp%0d_we", k),     128'(mem_req_we),       128'(1));
      check($sformatf("bp%0d_wdata", k),  128'(mem_req_wdata),    128'(64'hDEAD_BEEF));
      check($sformatf("bp%0d_id", k),     128'(mem_req_id),       128'(1));
      check($sformatf("bp%0d_iready", k), 128'(icache_req_ready), 128'(0));
      check($sformatf("bp%0d_dready", k), 128'(dcache_req_ready), 128'(0));
    end
    @(posedge clk); #1;
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
    mem_req_ready    = 1'b1;
    @(negedge clk);
    check("bp_drain_valid", 128'(mem_req_valid), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_empty", 128'(mem_req_valid), 128'(0));

    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("sb_left", 128'(sb_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/refill_req_arbiter.md
# refill_req_arbiter

Two-requester round-robin arbiter that shares the single L1.5/memory request channel between the instruction-cache refill path and the data-cache miss/write-through path. It registers the winning request, holds it stable until the memory side accepts it, and tracks outstanding transactions per requester. It routes each response back to its originator by source ID. It sits between the icache/dcache controllers and the OpenPiton L1.5 adapter.

## Interface
- AddrWidth, 64, physical request address width
- LineWidth, 128, response data width (one cache line)
- WDataWidth, 64, dcache write data width
- MaxOutstanding, 4, maximum in-flight requests per requester; must be ≥ 1
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- icache_req_valid_i / icache_req_ready_o  in/out  1  icache request handshake
- icache_req_addr_i  in  AddrWidth  icache refill address
- dcache_req_valid_i / dcache_req_ready_o  in/out  1  dcache request handshake
- dcache_req_addr_i  in  AddrWidth  dcache address
- dcache_req_we_i  in  1  1 = write-through store, 0 = read miss
- dcache_req_wdata_i  in  WDataWidth  store data
- mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake
- mem_req_addr_o  out  AddrWidth; mem_req_we_o  out  1; mem_req_wdata_o  out  WDataWidth
- mem_req_id_o  out  1  source: 0 = icache, 1 = dcache
- mem_rsp_valid_i  in  1  response strobe, never back-pressured
- mem_rsp_id_i  in  1  response source ID
- mem_rsp_data_i  in  LineWidth  response data
- icache_rsp_valid_o, dcache_rsp_valid_o  out  1  routed response strobes
- icache_rsp_data_o, dcache_rsp_data_o  out  LineWidth  routed response data
- err_o  out  1  sticky: response received for a requester with zero outstanding

## Operation
- Output register: one slot holding valid, addr, we, wdata, and id. FSM has two states. IDLE: slot empty. BUSY: slot full.
- Slot is free this cycle when the FSM is IDLE, or when it is BUSY and mem_req_ready_i = 1. A full slot drained in the same cycle it is refilled supports back-to-back operation.
- Eligibility: requester r is eligible when req_valid = 1 and cnt[r] < MaxOutstanding.
- Grant (combinational):
  - Only one requester eligible: it wins.
  - Both eligible: the one not granted most recently wins.
  - Last-grant pointer resets to dcache, so icache wins the first tie.
- req_ready_o = slot free AND requester is the winner. Ready never asserts to a non-winner. Ready may depend combinationally on mem_req_ready_i.
- On accept (valid & ready):
  - Load the slot. icache: we = 0, wdata = 0, id = 0. dcache: id = 1.
  - Update the last-grant pointer.
  - Increment cnt[r].
  - FSM goes to BUSY.
- When BUSY with mem_req_ready_i = 1 and no new accept, the FSM goes to IDLE.
- While BUSY and not accepted, mem_req_* hold stable.
- Counters are $clog2(MaxOutstanding+1) bits wide. A response decrements cnt[mem_rsp_id_i]. If an accept and a response for the same requester land in one cycle, the count is unchanged.
- A response arriving while cnt[id] = 0 leaves cnt unchanged, sets err_o, and still forwards the response strobe.
- Response routing is combinational:
  - icache_rsp_valid_o = mem_rsp_valid_i & (id == 0).
  - dcache_rsp_valid_o = mem_rsp_valid_i & (id == 1).
  - Both data outputs = mem_rsp_data_i.
- Reset, including mid-transaction:
  - FSM goes to IDLE; slot valid, addr, we, wdata, and id clear to 0.
  - Counters clear to 0; pointer resets to dcache; err_o clears to 0.
  - In-flight transactions are forgotten. Their later responses set err_o.

## Timing
- Reset values: mem_req_valid_o = 0, mem_req_addr_o = 0, mem_req_we_o = 0, mem_req_wdata_o = 0, mem_req_id_o = 0, err_o = 0.
- Reset values of combinational outputs: both req_ready_o = 1 when their requester is the eligible winner, else 0. Both rsp_valid_o follow their inputs.
- Request latency: accept in cycle N → mem_req_valid_o = 1 in cycle N+1.
- Throughput: one request per cycle while mem_req_ready_i = 1.
- Response latency: 0 cycles, combinational pass-through.
- err_o sets in the cycle after the offending response and stays set until reset.
- The counter increments in the cycle after the accept. Eligibility for cycle N+1 already reflects an accept in cycle N.

## Test plan
- Contention: after reset, both requesters are valid continuously and mem_req_ready_i = 1. Required: mem_req_id_o sequence 0,1,0,1… starting in cycle 1, with one handshake per cycle.
- Back-pressure: the dcache write (addr 0x80001000, wdata 0xDEADBEEF) is accepted while mem_req_ready_i = 0 for 5 cycles. Required: all mem_req_* stable for 5 cycles and both req_ready_o = 0 throughout. The slot drains on the ready cycle.
- Outstanding limit (MaxOutstanding = 4): icache issues 4 requests and no responses return. Required: icache_req_ready_o stays 0 while dcache is still granted. One id-0 response re-enables icache in the next cycle.
- Simultaneous events: an icache accept and an id-0 response occur in the same cycle with cnt = 2. Required: cnt stays 2, and icache_rsp_valid_o pulses in that cycle.
- Routing and error: an id-1 response arrives with data 0x…A5 while cnt[1] = 0. Required: dcache_rsp_valid_o pulses with that data, err_o = 1 from the next cycle, and cnt[1] stays 0.
- Mid-operation reset: rst_ni is driven low for one cycle while BUSY with cnt = {3,2}. Required: mem_req_valid_o = 0, counters = 0, and err_o = 0 in the next cycle. The next tie is granted to icache.
